// File: rtl/pin_debounce.sv
// Per-pin debouncer: two-flop synchroniser, per-bit stability counter, and
// one-cycle rise/fall pulses on each accepted level change.
module pin_debounce #(
   parameter int unsigned BIT_WIDTH     = 8,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter int unsigned STABLE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [BIT_WIDTH-1:0] in,
   output logic [BIT_WIDTH-1:0] level,
   output logic [BIT_WIDTH-1:0] rise,
   output logic [BIT_WIDTH-1:0] fall,
   output logic                 any_edge
);

   localparam longint unsigned CntMax = (64'd1 << CNT_WIDTH) - 64'd1;

   // The counter must be able to hold STABLE_CYCLES-1 without wrapping.
   if (STABLE_CYCLES == 0 || 64'(STABLE_CYCLES) > CntMax) begin : g_bad_param
      $error("pin_debounce: STABLE_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
   end

   localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic [BIT_WIDTH-1:0]                s1_q, s2_q;
   logic [BIT_WIDTH-1:0]                level_q, level_d;
   logic [BIT_WIDTH-1:0]                rise_q, rise_d;
   logic [BIT_WIDTH-1:0]                fall_q, fall_d;
   logic [BIT_WIDTH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= in;
         s2_q    <= s1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any return to the current level wipes the count; no partial credit.
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      cnt_d   = cnt_q;
      for (int i = 0; i < int'(BIT_WIDTH); i++) begin
         if (s2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            level_d[i] = s2_q[i];
            cnt_d[i]   = '0;
            rise_d[i]  = s2_q[i];
            fall_d[i]  = ~s2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   assign level    = level_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign any_edge = |{rise_q, fall_q};

endmodule

// File: tb/tb_pin_debounce.sv
// Directed bench for pin_debounce: vector table plus hand-written sequences
// for glitches, reset, staggered bits and the STABLE_CYCLES corner values.
module tb_pin_debounce;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [7:0] in4, in1, in15;
   logic [7:0] level4, rise4, fall4;
   logic [7:0] level1, rise1, fall1;
   logic [7:0] level15, rise15, fall15;
   logic       any4, any1, any15;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pin_debounce #(.BIT_WIDTH(8), .CNT_WIDTH(4), .STABLE_CYCLES(4)) u_dut (
      .clk(clk), .n_rst(n_rst), .in(in4),
      .level(level4), .rise(rise4), .fall(fall4), .any_edge(any4));

   pin_debounce #(.BIT_WIDTH(8), .CNT_WIDTH(4), .STABLE_CYCLES(1)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .in(in1),
      .level(level1), .rise(rise1), .fall(fall1), .any_edge(any1));

   pin_debounce #(.BIT_WIDTH(8), .CNT_WIDTH(4), .STABLE_CYCLES(15)) u_dut15 (
      .clk(clk), .n_rst(n_rst), .in(in15),
      .level(level15), .rise(rise15), .fall(fall15), .any_edge(any15));

   typedef struct {
      logic [7:0] vin;
      int         edges;
      logic [7:0] exp_level;
      logic [7:0] exp_rise;
      logic [7:0] exp_fall;
      logic       exp_any;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check4(input string name, input logic [7:0] lvl, input logic [7:0] r,
                         input logic [7:0] f, input logic a);
      check({name, ".level"}, level4, lvl);
      check({name, ".rise"}, rise4, r);
      check({name, ".fall"}, fall4, f);
      check({name, ".any_edge"}, {7'd0, any4}, {7'd0, a});
   endtask

   // Advance n active edges, landing 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vecs[0]  = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{8'h01, 5, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{8'h01, 1, 8'h01, 8'h01, 8'h00, 1'b1};
      vecs[3]  = '{8'h01, 1, 8'h01, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{8'h0F, 6, 8'h0F, 8'h0E, 8'h00, 1'b1};
      vecs[5]  = '{8'h0F, 1, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[6]  = '{8'h3C, 5, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[7]  = '{8'h3C, 1, 8'h3C, 8'h30, 8'h03, 1'b1};
      vecs[8]  = '{8'h3C, 1, 8'h3C, 8'h00, 8'h00, 1'b0};
      vecs[9]  = '{8'h00, 6, 8'h00, 8'h00, 8'h3C, 1'b1};
      vecs[10] = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0};

      // Reset held with all pins high
      n_rst = 1'b0;
      in4 = 8'hFF; in1 = 8'h00; in15 = 8'h00;
      #1;
      check4("reset_async", 8'h00, 8'h00, 8'h00, 1'b0);
      step(3);
      check4("reset_held", 8'h00, 8'h00, 8'h00, 1'b0);
      n_rst = 1'b1;
      step(1);
      check4("reset_release", 8'h00, 8'h00, 8'h00, 1'b0);
      in4 = 8'h00;
      step(10);
      check4("reset_settle", 8'h00, 8'h00, 8'h00, 1'b0);

      // Vector table: clean rise, multi-bit rise, mixed rise/fall, fall
      for (int v = 0; v < 11; v++) begin
         in4 = vecs[v].vin;
         step(vecs[v].edges);
         check4($sformatf("vec%0d", v), vecs[v].exp_level, vecs[v].exp_rise,
                vecs[v].exp_fall, vecs[v].exp_any);
      end

      // Glitch rejection on bit 3: high 3, low 1, ten times
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 4; c++) begin
            in4 = (c < 3) ? 8'h08 : 8'h00;
            step(1);
            check4($sformatf("glitch_r%0d_c%0d", r, c), 8'h00, 8'h00, 8'h00, 1'b0);
         end
      end
      in4 = 8'h08;
      step(5);
      check4("glitch_hold_e5", 8'h00, 8'h00, 8'h00, 1'b0);
      step(1);
      check4("glitch_hold_e6", 8'h08, 8'h08, 8'h00, 1'b1);

      // Asynchronous reset with a nonzero level, then reacquire
      n_rst = 1'b0;
      #1;
      check4("async_clear", 8'h00, 8'h00, 8'h00, 1'b0);
      step(2);
      n_rst = 1'b1;
      step(5);
      check4("reacq_e5", 8'h00, 8'h00, 8'h00, 1'b0);
      step(1);
      check4("reacq_e6", 8'h08, 8'h08, 8'h00, 1'b1);
      in4 = 8'h00;
      step(6);
      check4("reacq_fall", 8'h00, 8'h00, 8'h08, 1'b1);

      // Reset in the middle of a count discards the progress
      in4 = 8'h01;
      step(4);
      n_rst = 1'b0;
      step(2);
      n_rst = 1'b1;
      step(5);
      check4("midcnt_e5", 8'h00, 8'h00, 8'h00, 1'b0);
      step(1);
      check4("midcnt_e6", 8'h01, 8'h01, 8'h00, 1'b1);
      in4 = 8'h00;
      step(6);
      check4("midcnt_fall", 8'h00, 8'h00, 8'h01, 1'b1);

      // Staggered bits: bit 7 starts two edges after bit 1
      in4 = 8'h02;
      for (int e = 1; e <= 10; e++) begin
         logic [7:0] er, el;
         if (e == 3) in4 = 8'h82;
         step(1);
         er = (e == 6) ? 8'h02 : (e == 8) ? 8'h80 : 8'h00;
         el = (e < 6) ? 8'h00 : (e < 8) ? 8'h02 : 8'h82;
         check4($sformatf("stagger_e%0d", e), el, er, 8'h00, (er != 8'h00));
      end
      in4 = 8'h00;
      step(6);
      check4("stagger_fall", 8'h00, 8'h00, 8'h82, 1'b1);

      // Input refreshed only every other cycle
      for (int e = 1; e <= 6; e++) begin
         if (e % 2 == 1) in4 = 8'h10;
         step(1);
         if (e == 5) check4("alt_e5", 8'h00, 8'h00, 8'h00, 1'b0);
         if (e == 6) check4("alt_e6", 8'h10, 8'h10, 8'h00, 1'b1);
      end

      // STABLE_CYCLES=1: accepted on edge 3
      in1 = 8'h01;
      step(2);
      check("sc1_e2.level", level1, 8'h00);
      check("sc1_e2.rise", rise1, 8'h00);
      step(1);
      check("sc1_e3.level", level1, 8'h01);
      check("sc1_e3.rise", rise1, 8'h01);
      check("sc1_e3.any", {7'd0, any1}, 8'h01);
      step(1);
      check("sc1_e4.rise", rise1, 8'h00);
      in1 = 8'h00;
      step(3);
      check("sc1_fall.fall", fall1, 8'h01);
      check("sc1_fall.level", level1, 8'h00);

      // STABLE_CYCLES=15 with a 4-bit counter: edge 17, no wrap
      in15 = 8'h01;
      step(16);
      check("sc15_e16.level", level15, 8'h00);
      check("sc15_e16.rise", rise15, 8'h00);
      step(1);
      check("sc15_e17.level", level15, 8'h01);
      check("sc15_e17.rise", rise15, 8'h01);
      check("sc15_e17.any", {7'd0, any15}, 8'h01);
      for (int e = 18; e <= 40; e++) begin
         step(1);
         check($sformatf("sc15_hold_e%0d", e), {level15[7:1], level15[0] & ~rise15[0] & ~fall15[0]}, 8'h01);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
